// File: rtl/fp_expand_serial.sv
// Serial expander: rebuilds a 12-bit two's-complement linear sample from
// sign/exponent/significand, one left shift per clock, with valid/ready on both sides.
module fp_expand_serial (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sign,
    input  logic [2:0]  exponent,
    input  logic [3:0]  significand,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] D_out
);

    localparam int unsigned EXP_W = 3;
    localparam int unsigned SIG_W = 4;
    localparam int unsigned OUT_W = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIX   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [OUT_W-1:0]   mag_q, mag_d;
    logic [EXP_W-1:0]   cnt_q, cnt_d;
    logic               sgn_q, sgn_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   d_out_q, d_out_d;

    // Next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        mag_d       = mag_q;
        cnt_d       = cnt_q;
        sgn_d       = sgn_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        d_out_d     = d_out_q;

        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    mag_d      = {(OUT_W - SIG_W)'(0), significand};
                    cnt_d      = exponent;
                    sgn_d      = sign;
                    in_ready_d = 1'b0;
                    state_d    = (exponent != '0) ? SHIFT : FIX;
                end
            end
            SHIFT: begin
                mag_d = {mag_q[OUT_W-2:0], 1'b0};
                cnt_d = EXP_W'(cnt_q - EXP_W'(1));
                if (cnt_q == EXP_W'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                // Negating zero yields zero, so no negative-zero special case is needed
                d_out_d     = sgn_q ? OUT_W'(OUT_W'(0) - mag_q) : mag_q;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mag_q       <= '0;
            cnt_q       <= '0;
            sgn_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            d_out_q     <= '0;
        end else begin
            state_q     <= state_d;
            mag_q       <= mag_d;
            cnt_q       <= cnt_d;
            sgn_q       <= sgn_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            d_out_q     <= d_out_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign D_out     = d_out_q;

endmodule

// File: tb/tb_fp_expand_serial.sv
// Directed self-checking bench for fp_expand_serial.
module tb_fp_expand_serial;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        sign;
    logic [2:0]  exponent;
    logic [3:0]  significand;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] D_out;

    int total  = 0;
    int passes = 0;
    int fails  = 0;

    fp_expand_serial dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .sign        (sign),
        .exponent    (exponent),
        .significand (significand),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .D_out       (D_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic scramble();
        sign        = 1'($urandom);
        exponent    = 3'($urandom);
        significand = 4'($urandom);
    endtask

    // Accept one sample, measure latency (accept edge counted as edge 1), check result.
    // With hold=0 and out_ready=1 the handshake that follows is checked too.
    task automatic run_sample(input string tag, input logic s, input logic [2:0] e,
                              input logic [3:0] m, input logic [11:0] exp_d, input logic hold);
        int n;
        int lat;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid    = 1'b1;
        sign        = s;
        exponent    = e;
        significand = m;
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble();
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(e) + 32'd2);
        chk({tag, "_dout"}, 32'(D_out), 32'(exp_d));
        chk({tag, "_busy"}, 32'(in_ready), 32'd0);
        if (!hold) begin
            @(posedge clk); #1;
            chk({tag, "_hs_valid"}, 32'(out_valid), 32'd0);
            chk({tag, "_hs_ready"}, 32'(in_ready), 32'd1);
            chk({tag, "_hs_dout"}, 32'(D_out), 32'(exp_d));
        end
    endtask

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        scramble();
        #1 rst_n = 1'b0;

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'($urandom);
            scramble();
            @(posedge clk); #1;
        end
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_dout", 32'(D_out), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        run_sample("pos_e3", 1'b0, 3'd3, 4'd10, 12'h050, 1'b0);
        run_sample("max_neg", 1'b1, 3'd7, 4'd15, 12'h880, 1'b0);
        run_sample("e0_one", 1'b0, 3'd0, 4'd1, 12'h001, 1'b0);
        run_sample("zero_neg", 1'b1, 3'd5, 4'd0, 12'h000, 1'b0);
        run_sample("neg12", 1'b1, 3'd2, 4'd3, 12'hFF4, 1'b0);

        // Backpressure in DONE
        out_ready = 1'b0;
        run_sample("bp", 1'b0, 3'd4, 4'd7, 12'h070, 1'b1);
        for (int i = 0; i < 10; i++) begin
            in_valid = ~in_valid;
            scramble();
            @(posedge clk); #1;
            chk("bp_dout", 32'(D_out), 32'h070);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_hs_valid", 32'(out_valid), 32'd0);
        chk("bp_hs_ready", 32'(in_ready), 32'd1);
        chk("bp_hs_dout", 32'(D_out), 32'h070);
        run_sample("after_bp", 1'b1, 3'd1, 4'd5, 12'hFF6, 1'b0);

        // Mid-operation reset during SHIFT
        in_valid    = 1'b1;
        sign        = 1'b0;
        exponent    = 3'd6;
        significand = 4'd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_dout", 32'(D_out), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (i == 3) rst_n = 1'b1;
            chk("mid_rst_no_valid", 32'(out_valid), 32'd0);
        end
        run_sample("post_mid_rst", 1'b0, 3'd1, 4'd9, 12'h012, 1'b0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
